// File: rtl/vga_rect_fill_if.sv
// Bus bundle for the rectangle-fill engine: CPU register writes in, masked SDRAM writes out,
// plus busy/done status.
interface vga_rect_fill_if;
    logic        hwregs_write;
    logic [7:0]  hwregs_addr;
    logic [31:0] hwregs_wdata;

    logic        sdram_request;
    logic        sdram_ready;
    logic [25:0] sdram_address;
    logic        sdram_write;
    logic [31:0] sdram_wdata;
    logic [3:0]  sdram_wmask;

    logic        busy;
    logic        done;

    // The fill engine masters the SDRAM port and receives register writes.
    modport master (
        input  hwregs_write, hwregs_addr, hwregs_wdata, sdram_ready,
        output sdram_request, sdram_address, sdram_write, sdram_wdata, sdram_wmask,
        output busy, done
    );

    modport slave (
        output hwregs_write, hwregs_addr, hwregs_wdata, sdram_ready,
        input  sdram_request, sdram_address, sdram_write, sdram_wdata, sdram_wmask,
        input  busy, done
    );
endinterface

// File: rtl/vga_rect_fill.sv
// Rectangle-fill engine: writes an 8bpp colour over a WIDTH x HEIGHT pixel rectangle in the
// framebuffer using single-word byte-masked SDRAM writes, one per grant.
module vga_rect_fill #(
    parameter int unsigned DIM_W    = 10,
    parameter int unsigned STRIDE_W = 16
) (
    input logic             clock,
    input logic             reset,
    vga_rect_fill_if.master bus
);
    typedef enum logic [1:0] {StIdle, StSetup, StWrite} state_e;

    // Pixels that fit in the current word: min(4 - offset, remaining).
    function automatic logic [2:0] word_count(input logic [1:0] offs,
                                              input logic [DIM_W-1:0] rem);
        logic [2:0] room;
        room = 3'd4 - {1'b0, offs};
        if (rem >= DIM_W'(room)) return room;
        return rem[2:0];
    endfunction

    function automatic logic [3:0] word_mask(input logic [1:0] offs, input logic [2:0] cnt);
        logic [3:0] m;
        for (int i = 0; i < 4; i++) begin
            m[i] = (3'(i) >= {1'b0, offs}) && (3'(i) < ({1'b0, offs} + cnt));
        end
        return m;
    endfunction

    state_e              state_q;

    // Programmed registers
    logic [25:0]         base_q;
    logic [STRIDE_W-1:0] stride_q;
    logic [DIM_W-1:0]    width_q;
    logic [DIM_W-1:0]    height_q;
    logic [7:0]          colour_q;

    // Working copies latched on an accepted START
    logic [STRIDE_W-1:0] stride_w_q;
    logic [DIM_W-1:0]    width_w_q;
    logic [DIM_W-1:0]    rows_left_q;
    logic [25:0]         row_addr_q;
    logic [25:0]         cur_q;
    logic [DIM_W-1:0]    rem_q;

    logic                request_q;
    logic                write_q;
    logic [25:0]         address_q;
    logic [31:0]         wdata_q;
    logic [3:0]          wmask_q;
    logic                busy_q;
    logic                done_q;

    logic                accept;
    logic                start;
    logic [2:0]          cur_cnt;
    logic [25:0]         cur_next;
    logic [DIM_W-1:0]    rem_next;
    logic [3:0]          next_mask;
    logic [3:0]          setup_mask;
    logic                unused_wdata;

    assign unused_wdata = ^bus.hwregs_wdata[31:26];

    always_comb begin
        accept     = request_q && bus.sdram_ready;
        start      = bus.hwregs_write && (bus.hwregs_addr == 8'h14);
        cur_cnt    = word_count(cur_q[1:0], rem_q);
        cur_next   = cur_q + 26'(cur_cnt);
        rem_next   = rem_q - DIM_W'(cur_cnt);
        next_mask  = word_mask(cur_next[1:0], word_count(cur_next[1:0], rem_next));
        setup_mask = word_mask(row_addr_q[1:0], word_count(row_addr_q[1:0], width_w_q));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StIdle;
            base_q      <= '0;
            stride_q    <= '0;
            width_q     <= '0;
            height_q    <= '0;
            colour_q    <= '0;
            stride_w_q  <= '0;
            width_w_q   <= '0;
            rows_left_q <= '0;
            row_addr_q  <= '0;
            cur_q       <= '0;
            rem_q       <= '0;
            request_q   <= 1'b0;
            write_q     <= 1'b0;
            address_q   <= '0;
            wdata_q     <= '0;
            wmask_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;

            if (bus.hwregs_write) begin
                case (bus.hwregs_addr)
                    8'h00:   base_q   <= bus.hwregs_wdata[25:0];
                    8'h04:   stride_q <= bus.hwregs_wdata[STRIDE_W-1:0];
                    8'h08:   width_q  <= bus.hwregs_wdata[DIM_W-1:0];
                    8'h0C:   height_q <= bus.hwregs_wdata[DIM_W-1:0];
                    8'h10:   colour_q <= bus.hwregs_wdata[7:0];
                    default: ;
                endcase
            end

            case (state_q)
                StIdle: begin
                    if (start) begin
                        if (width_q != '0 && height_q != '0) begin
                            row_addr_q  <= base_q;
                            stride_w_q  <= stride_q;
                            width_w_q   <= width_q;
                            rows_left_q <= height_q;
                            wdata_q     <= {4{colour_q}};
                            busy_q      <= 1'b1;
                            state_q     <= StSetup;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                StSetup: begin
                    cur_q     <= row_addr_q;
                    rem_q     <= width_w_q;
                    address_q <= {row_addr_q[25:2], 2'b00};
                    wmask_q   <= setup_mask;
                    request_q <= 1'b1;
                    write_q   <= 1'b1;
                    state_q   <= StWrite;
                end
                StWrite: begin
                    if (accept) begin
                        cur_q <= cur_next;
                        rem_q <= rem_next;
                        if (rem_next != '0) begin
                            address_q <= {cur_next[25:2], 2'b00};
                            wmask_q   <= next_mask;
                        end else begin
                            request_q <= 1'b0;
                            write_q   <= 1'b0;
                            wmask_q   <= '0;
                            if (rows_left_q > DIM_W'(1)) begin
                                rows_left_q <= rows_left_q - DIM_W'(1);
                                row_addr_q  <= row_addr_q + 26'(stride_w_q);
                                state_q     <= StSetup;
                            end else begin
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                                state_q <= StIdle;
                            end
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.sdram_request = request_q;
    assign bus.sdram_write   = write_q;
    assign bus.sdram_address = address_q;
    assign bus.sdram_wdata   = wdata_q;
    assign bus.sdram_wmask   = wmask_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
endmodule

// File: tb/tb_vga_rect_fill.sv
// Directed bench for vga_rect_fill: programs fills, tracks every accepted SDRAM write and
// compares address/mask/data/status against hand-computed values.
module tb_vga_rect_fill;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   failed = 0;
    int   accepts = 0;
    int   waited;
    int   base_acc;

    vga_rect_fill_if bus_if ();

    vga_rect_fill #(.DIM_W(10), .STRIDE_W(16)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (bus_if.sdram_request && bus_if.sdram_ready) accepts <= accepts + 1;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic reg_write(input logic [7:0] a, input logic [31:0] d);
        bus_if.hwregs_write = 1'b1;
        bus_if.hwregs_addr  = a;
        bus_if.hwregs_wdata = d;
        step();
        bus_if.hwregs_write = 1'b0;
    endtask

    // Waits (bounded) for an accept, checks the word presented, then lets the accept happen.
    task automatic expect_write(input string tag, input logic [25:0] a, input logic [3:0] m,
                                input logic [31:0] d, output int w);
        w = 0;
        while (!(bus_if.sdram_request && bus_if.sdram_ready) && w < 64) begin
            step();
            w++;
        end
        chk({tag, " request"}, {31'd0, bus_if.sdram_request}, 32'd1);
        chk({tag, " write"}, {31'd0, bus_if.sdram_write}, 32'd1);
        chk({tag, " address"}, {6'd0, bus_if.sdram_address}, {6'd0, a});
        chk({tag, " wmask"}, {28'd0, bus_if.sdram_wmask}, {28'd0, m});
        chk({tag, " wdata"}, bus_if.sdram_wdata, d);
        step();
    endtask

    task automatic expect_done(input string tag);
        chk({tag, " done"}, {31'd0, bus_if.done}, 32'd1);
        chk({tag, " busy"}, {31'd0, bus_if.busy}, 32'd0);
        chk({tag, " request"}, {31'd0, bus_if.sdram_request}, 32'd0);
    endtask

    initial begin
        bus_if.hwregs_write = 1'b0;
        bus_if.hwregs_addr  = '0;
        bus_if.hwregs_wdata = '0;
        bus_if.sdram_ready  = 1'b1;

        repeat (3) step();
        chk("rst request", {31'd0, bus_if.sdram_request}, 32'd0);
        chk("rst write", {31'd0, bus_if.sdram_write}, 32'd0);
        chk("rst busy", {31'd0, bus_if.busy}, 32'd0);
        chk("rst done", {31'd0, bus_if.done}, 32'd0);
        chk("rst wmask", {28'd0, bus_if.sdram_wmask}, 32'd0);
        chk("rst address", {6'd0, bus_if.sdram_address}, 32'd0);
        reset = 1'b0;
        step();

        // Single aligned word, with start latency checks
        reg_write(8'h00, 32'h1000);
        reg_write(8'h08, 32'd4);
        reg_write(8'h0C, 32'd1);
        reg_write(8'h10, 32'h5A);
        base_acc = accepts;
        reg_write(8'h14, 32'd0);
        chk("t1 busy N+1", {31'd0, bus_if.busy}, 32'd1);
        chk("t1 request N+1", {31'd0, bus_if.sdram_request}, 32'd0);
        step();
        chk("t1 request N+2", {31'd0, bus_if.sdram_request}, 32'd1);
        expect_write("t1 w0", 26'h1000, 4'b1111, 32'h5A5A5A5A, waited);
        expect_done("t1");
        step();
        chk("t1 done pulse", {31'd0, bus_if.done}, 32'd0);
        chk("t1 accepts", accepts - base_acc, 32'd1);

        // Unaligned start spanning three words, back-to-back
        reg_write(8'h00, 32'h1003);
        reg_write(8'h08, 32'd6);
        reg_write(8'h14, 32'd0);
        expect_write("t2 w0", 26'h1000, 4'b1000, 32'h5A5A5A5A, waited);
        expect_write("t2 w1", 26'h1004, 4'b1111, 32'h5A5A5A5A, waited);
        chk("t2 w1 back-to-back", waited, 32'd0);
        expect_write("t2 w2", 26'h1008, 4'b0001, 32'h5A5A5A5A, waited);
        chk("t2 w2 back-to-back", waited, 32'd0);
        expect_done("t2");

        // Three rows with stride
        reg_write(8'h00, 32'h2001);
        reg_write(8'h04, 32'h100);
        reg_write(8'h08, 32'd2);
        reg_write(8'h0C, 32'd3);
        base_acc = accepts;
        reg_write(8'h14, 32'd0);
        expect_write("t3 r0", 26'h2000, 4'b0110, 32'h5A5A5A5A, waited);
        expect_write("t3 r1", 26'h2100, 4'b0110, 32'h5A5A5A5A, waited);
        expect_write("t3 r2", 26'h2200, 4'b0110, 32'h5A5A5A5A, waited);
        expect_done("t3");
        repeat (5) step();
        chk("t3 accepts", accepts - base_acc, 32'd3);

        // Grant withheld for 20 cycles mid-row
        reg_write(8'h00, 32'h3000);
        reg_write(8'h08, 32'd8);
        reg_write(8'h0C, 32'd1);
        base_acc = accepts;
        reg_write(8'h14, 32'd0);
        expect_write("t4 w0", 26'h3000, 4'b1111, 32'h5A5A5A5A, waited);
        bus_if.sdram_ready = 1'b0;
        repeat (20) step();
        chk("t4 stall request", {31'd0, bus_if.sdram_request}, 32'd1);
        chk("t4 stall address", {6'd0, bus_if.sdram_address}, 32'h3004);
        chk("t4 stall wmask", {28'd0, bus_if.sdram_wmask}, 32'hF);
        chk("t4 stall wdata", bus_if.sdram_wdata, 32'h5A5A5A5A);
        chk("t4 stall accepts", accepts - base_acc, 32'd1);
        bus_if.sdram_ready = 1'b1;
        expect_write("t4 w1", 26'h3004, 4'b1111, 32'h5A5A5A5A, waited);
        expect_done("t4");
        chk("t4 accepts", accepts - base_acc, 32'd2);

        // Zero width: immediate done, no traffic
        reg_write(8'h08, 32'd0);
        base_acc = accepts;
        reg_write(8'h14, 32'd0);
        chk("t5 done", {31'd0, bus_if.done}, 32'd1);
        chk("t5 busy", {31'd0, bus_if.busy}, 32'd0);
        step();
        chk("t5 done pulse", {31'd0, bus_if.done}, 32'd0);
        repeat (5) step();
        chk("t5 request", {31'd0, bus_if.sdram_request}, 32'd0);
        chk("t5 accepts", accepts - base_acc, 32'd0);

        // START while busy ignored; BASE written mid-fill only affects the next fill
        reg_write(8'h00, 32'h4000);
        reg_write(8'h04, 32'h10);
        reg_write(8'h08, 32'd4);
        reg_write(8'h0C, 32'd2);
        bus_if.sdram_ready = 1'b0;
        base_acc = accepts;
        reg_write(8'h14, 32'd0);
        step();
        reg_write(8'h00, 32'h5000);
        reg_write(8'h14, 32'd0);
        chk("t6 busy", {31'd0, bus_if.busy}, 32'd1);
        bus_if.sdram_ready = 1'b1;
        expect_write("t6 r0", 26'h4000, 4'b1111, 32'h5A5A5A5A, waited);
        expect_write("t6 r1", 26'h4010, 4'b1111, 32'h5A5A5A5A, waited);
        expect_done("t6");
        repeat (10) step();
        chk("t6 accepts", accepts - base_acc, 32'd2);
        chk("t6 idle busy", {31'd0, bus_if.busy}, 32'd0);

        // Reset mid-fill
        reg_write(8'h08, 32'd8);
        reg_write(8'h14, 32'd0);
        expect_write("t7 w0", 26'h5000, 4'b1111, 32'h5A5A5A5A, waited);
        reset = 1'b1;
        bus_if.sdram_ready = 1'b0;
        step();
        chk("t7 rst request", {31'd0, bus_if.sdram_request}, 32'd0);
        chk("t7 rst busy", {31'd0, bus_if.busy}, 32'd0);
        chk("t7 rst done", {31'd0, bus_if.done}, 32'd0);
        reset = 1'b0;
        bus_if.sdram_ready = 1'b1;
        base_acc = accepts;
        repeat (10) step();
        chk("t7 no pending write", accepts - base_acc, 32'd0);
        // Registers are cleared by reset, so START is a zero-size fill
        reg_write(8'h14, 32'd0);
        chk("t7 zero regs done", {31'd0, bus_if.done}, 32'd1);
        chk("t7 zero regs busy", {31'd0, bus_if.busy}, 32'd0);

        // Fresh fill after reset, then START in the done cycle
        reg_write(8'h00, 32'h6002);
        reg_write(8'h08, 32'd3);
        reg_write(8'h0C, 32'd1);
        reg_write(8'h10, 32'hC3);
        reg_write(8'h14, 32'd0);
        expect_write("t8 w0", 26'h6000, 4'b1100, 32'hC3C3C3C3, waited);
        expect_write("t8 w1", 26'h6004, 4'b0001, 32'hC3C3C3C3, waited);
        expect_done("t8");
        reg_write(8'h14, 32'd0);
        chk("t8 restart busy", {31'd0, bus_if.busy}, 32'd1);
        expect_write("t8 again w0", 26'h6000, 4'b1100, 32'hC3C3C3C3, waited);
        expect_write("t8 again w1", 26'h6004, 4'b0001, 32'hC3C3C3C3, waited);
        expect_done("t8 again");
        chk("t8 accepts", accepts - base_acc, 32'd4);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
